hazard_unit: RTL
================

Name: hazard_unit

Overview:
Pipeline hazard detector for the 5-stage MIPS core, sitting directly upstream of the NPC stage. It generates the Bubble input that freezes NPC and the IF/ID register, and it gates NPC's Flush into an IF/ID flush. It detects load-use and branch-operand hazards between ID and EX/MEM, and it tracks a multi-cycle mult/div unit with a busy counter. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
MUL_LAT, 4, cycles the mult unit is busy after a mult/multu is accepted (>=1)
DIV_LAT, 16, cycles the unit is busy after a div/divu is accepted (>=1)
CNT_W, 32, width of the stall-cycle counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
ID_rs  in  5  rs field of the instruction in ID
ID_rt  in  5  rt field of the instruction in ID
ID_uses_rs  in  1  ID instruction reads rs
ID_uses_rt  in  1  ID instruction reads rt
ID_is_branch  in  1  ID instruction resolves in ID (beq/bne/jr/jalr)
ID_reads_hilo  in  1  ID instruction is mfhi/mflo
ID_md_start  in  1  ID instruction is mult/multu/div/divu
ID_md_is_div  in  1  qualifies ID_md_start: 1=div, 0=mult
EX_MemRead  in  1  EX instruction is a load
EX_RegWrite  in  1  EX instruction writes the GPR file
EX_dst  in  5  destination register of the EX instruction
MEM_MemRead  in  1  MEM instruction is a load
MEM_dst  in  5  destination register of the MEM instruction
Flush  in  1  NPC redirect flag (registered in NPC)
Bubble  out  1  stall: freezes NPC and IF/ID
ifid_flush  out  1  zero the IF/ID register
idex_flush  out  1  insert a NOP into ID/EX
md_busy  out  1  mult/div unit occupied
md_done  out  1  one-cycle pulse on the last busy cycle
stall_cnt  out  CNT_W  count of cycles with Bubble=1

Behaviour:
- Reset: asynchronous, active-high. While rst=1, all outputs are 0, md state is IDLE, md counter is 0 and stall_cnt is 0.
- Matching: a source matches a destination only if both registers are equal, the destination is non-zero and the matching uses_* flag is 1.
- load_use: EX_MemRead and (rs match or rt match) against EX_dst.
- branch_haz: ID_is_branch and either:
  - EX_RegWrite with a match against EX_dst, or
  - MEM_MemRead with a match against MEM_dst.
- md_haz: md_busy and (ID_reads_hilo or ID_md_start).
- Bubble = load_use | branch_haz | md_haz. It is combinational, with zero latency, so NPC holds in the same cycle.
- idex_flush = Bubble.
- ifid_flush = Flush & ~Bubble. Bubble has priority, and the instruction in IF/ID is held, not flushed.
- md FSM, IDLE/BUSY:
  - IDLE -> BUSY on ID_md_start & ~Bubble & ~Flush. The counter loads DIV_LAT if ID_md_is_div, else MUL_LAT.
  - BUSY: the counter decrements each cycle. When the counter is 1, md_done=1 and the FSM goes to IDLE next cycle.
  - md_busy = (state==BUSY). It is registered, so it rises the cycle after acceptance.
  - There is no back-to-back overlap. A start in ID while BUSY stalls until the cycle after md_done, then is accepted.
  - A start arriving together with Flush (wrong-path instruction) is ignored.
- stall_cnt: increments on each rising edge where Bubble=1. It saturates at all-ones and does not wrap.
- Simultaneous hazards: all are OR'd, and there is a single Bubble per cycle.
- Reset mid-operation (BUSY): the FSM returns to IDLE immediately and md_done is not pulsed.

Test Plan:
- lw $8 in EX (EX_MemRead=1, EX_dst=8); ID add reads rs=8 -> Bubble=1, idex_flush=1 for exactly 1 cycle. Repeat with EX_dst=0 -> Bubble=0.
- ID beq rs=9 with EX_RegWrite=1, EX_dst=9 -> Bubble=1. Next cycle, MEM_MemRead=0 with the value in MEM -> Bubble=0. With MEM_MemRead=1, MEM_dst=9 -> Bubble=1 for one more cycle.
- ID div accepted at cycle t -> md_busy=1 for cycles t+1..t+16, md_done=1 at t+16. mfhi in ID during t+1..t+16 -> Bubble=1, released at t+17.
- Flush=1 with no hazard -> ifid_flush=1. Flush=1 with load_use -> ifid_flush=0, Bubble=1. ID_md_start with Flush=1 -> md_busy stays 0.
- Force Bubble=1 for 10 cycles from reset -> stall_cnt=10. With CNT_W=4 and 20 stall cycles -> stall_cnt=15.
- Assert rst during BUSY (counter=7) -> md_busy=0, all outputs 0 immediately. After release, a new mult gives md_busy=1 for 4 cycles.

Source files
------------

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard detector for the 5-stage MIPS core. It sits directly upstream
// of the NPC stage and does four jobs:
//   - Raises Bubble when ID must wait for an older instruction:
//       * load-use: a load in EX writes a register that ID reads.
//       * branch operands: a branch resolved in ID depends on EX or on a load in MEM.
//       * mult/div: the HI/LO unit is busy.
//     Bubble freezes NPC and IF/ID and puts a NOP into ID/EX.
//   - Turns NPC's registered Flush into an IF/ID flush. Bubble has priority over it.
//   - Tracks the multi-cycle mult/div unit with an IDLE/BUSY FSM and a down-counter.
//   - Counts stalled cycles in a saturating counter for performance debug.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   ID_rs/ID_rt         source fields of the instruction in ID
//   ID_uses_rs/rt       qualify whether ID really reads rs/rt
//   ID_is_branch        ID instruction resolves in ID (beq/bne/jr/jalr)
//   ID_reads_hilo       ID instruction is mfhi/mflo
//   ID_md_start         ID instruction is mult/multu/div/divu
//   ID_md_is_div        1 = div/divu, 0 = mult/multu
//   EX_MemRead/RegWrite/EX_dst  EX-stage load flag, write flag, destination
//   MEM_MemRead/MEM_dst         MEM-stage load flag and destination
//   Flush               NPC redirect flag
//   Bubble              stall for NPC and IF/ID
//   ifid_flush          zero the IF/ID register
//   idex_flush          insert a NOP into ID/EX
//   md_busy             mult/div unit occupied (registered)
//   md_done             one-cycle pulse on the last busy cycle
//   stall_cnt           saturating count of cycles with Bubble=1
// -----------------------------------------------------------------------------
module hazard_unit #(
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned DIV_LAT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_uses_rs,
   input  logic             ID_uses_rt,
   input  logic             ID_is_branch,
   input  logic             ID_reads_hilo,
   input  logic             ID_md_start,
   input  logic             ID_md_is_div,
   input  logic             EX_MemRead,
   input  logic             EX_RegWrite,
   input  logic [4:0]       EX_dst,
   input  logic             MEM_MemRead,
   input  logic [4:0]       MEM_dst,
   input  logic             Flush,
   output logic             Bubble,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             md_busy,
   output logic             md_done,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
   localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic {
      StIdle,
      StBusy
   } md_state_t;

   md_state_t        r_state;
   logic [LAT_W-1:0] r_md_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
   logic w_ex_match, w_mem_match;
   logic w_load_use, w_branch_haz, w_md_haz;
   logic w_bubble;
   logic w_md_busy;
   logic w_md_accept;

   // Register $0 is hard-wired to zero, so a zero destination never creates a dependency.
   always_comb begin
      w_rs_ex  = ID_uses_rs && (ID_rs == EX_dst)  && (EX_dst  != 5'd0);
      w_rt_ex  = ID_uses_rt && (ID_rt == EX_dst)  && (EX_dst  != 5'd0);
      w_rs_mem = ID_uses_rs && (ID_rs == MEM_dst) && (MEM_dst != 5'd0);
      w_rt_mem = ID_uses_rt && (ID_rt == MEM_dst) && (MEM_dst != 5'd0);
   end

   assign w_ex_match  = w_rs_ex  | w_rt_ex;
   assign w_mem_match = w_rs_mem | w_rt_mem;

   assign w_md_busy    = (r_state == StBusy);
   assign w_load_use   = EX_MemRead & w_ex_match;
   assign w_branch_haz = ID_is_branch & ((EX_RegWrite & w_ex_match) |
                                         (MEM_MemRead & w_mem_match));
   assign w_md_haz     = w_md_busy & (ID_reads_hilo | ID_md_start);

   // Combinational so NPC holds in the same cycle. The reset term forces the outputs low
   // while rst is held, even if hazard inputs are present.
   assign w_bubble = ~rst & (w_load_use | w_branch_haz | w_md_haz);

   // A wrong-path start (with Flush) or a stalled start is never accepted. A start while
   // BUSY is already covered by w_md_haz, but the IDLE term keeps that explicit.
   assign w_md_accept = ID_md_start & ~w_bubble & ~Flush & (r_state == StIdle);

   assign Bubble     = w_bubble;
   assign idex_flush = w_bubble;
   assign ifid_flush = ~rst & Flush & ~w_bubble;
   assign md_busy    = w_md_busy;
   assign md_done    = w_md_busy & (r_md_cnt == LAT_W'(1));
   assign stall_cnt  = r_stall_cnt;

   // mult/div occupancy FSM. The counter holds the remaining busy cycles, including the
   // current one, so md_done fires while it reads 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= StIdle;
         r_md_cnt <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_md_accept) begin
                  r_state  <= StBusy;
                  r_md_cnt <= ID_md_is_div ? LAT_W'(DIV_LAT) : LAT_W'(MUL_LAT);
               end
            end
            StBusy: begin
               r_md_cnt <= r_md_cnt - LAT_W'(1);
               if (r_md_cnt == LAT_W'(1)) begin
                  r_state <= StIdle;
               end
            end
            default: begin
               r_state  <= StIdle;
               r_md_cnt <= '0;
            end
         endcase
      end
   end

   // Saturating stall counter: it sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_bubble && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

endmodule
